mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter byte, default 8, bits per byte.
REQ-002 SHALL have parameter width, default 4*byte, memory word width.
REQ-003 SHALL have parameter address_size, default 16, memory address width.
REQ-004 SHALL have parameter timeout_cycles, default 255, maximum WAIT cycles (1..255).
REQ-005 SHALL have ports: clk input 1, the single clock; reset input 1, asynchronous, active-high.
REQ-006 SHALL have ports (requester 0, instruction fetch, read-only): start_0 in 1, request strobe; address_0 in address_size, read address; ready_0 out 1, one-cycle done pulse; data_out_0 out width, read word.
REQ-007 SHALL have ports (requester 1, execute): start_1 in 1, request strobe; write_1 in 1, 1 = write; address_1 in address_size, address; data_in_1 in width, write data; ready_1 out 1, one-cycle done pulse; data_out_1 out width, read word.
REQ-008 SHALL have memory-side ports: start_for_memory out 1; write_for_memory out 1; address_for_memory out address_size; data_for_memory out width; data_from_memory in width; ready_from_memory in 1.
REQ-009 SHALL have status ports: grant out 2, one-hot owner (bit0 = req 0); busy out 1, state != IDLE; error out 1, one-cycle timeout pulse.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, updated on rising clk.
REQ-011 IDLE: if any start_N is high, SHALL select a winner, latch its address, write flag (0 for req 0) and write data, set grant, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-012 Arbitration SHALL be round-robin: on a tie the requester not granted last wins; last_grant resets to 1, so req 0 wins the first tie.
REQ-013 ISSUE SHALL assert start_for_memory for exactly one cycle with latched address/write/data, then go to WAIT.
REQ-014 address_for_memory, write_for_memory and data_for_memory SHALL hold the latched values from ISSUE through DONE, and SHALL be 0 in IDLE.
REQ-015 WAIT SHALL sample ready_from_memory each cycle; when high, SHALL capture data_from_memory into data_out_N of the granted requester on reads (unchanged on writes) and go to DONE.
REQ-016 WAIT SHALL count cycles; after timeout_cycles cycles without ready_from_memory, SHALL go to DONE, pulse error, leave data_out_N unchanged.
REQ-017 DONE SHALL assert ready_N of the granted requester for exactly one cycle, update last_grant, clear grant, and return to IDLE.
REQ-018 Minimum latency: start_N high at edge k -> start_for_memory during cycle k+1 -> ready_N high during cycle k+3 when ready_from_memory is high at the first WAIT edge.
REQ-019 ready_from_memory SHALL be ignored outside WAIT.
REQ-020 Requesters SHALL hold start_N and operands stable until ready_N; start_N still high in the IDLE cycle after DONE SHALL count as a new request.
REQ-021 Changes on a non-granted requester's inputs SHALL NOT affect the transaction in flight.
REQ-022 data_out_N SHALL hold its value until the next completed read for that requester.
REQ-023 ready_0 and ready_1 SHALL never be high in the same cycle; at most one transaction SHALL be outstanding.

Reset
REQ-024 reset high SHALL force, asynchronously: state IDLE, all outputs 0 (incl. data_out_0/1, grant, busy, error), WAIT counter 0, last_grant 1.
REQ-025 reset mid-transaction SHALL abandon it with no ready_N pulse; after release the arbiter SHALL restart from IDLE and re-arbitrate still-held start_N.

Verification
REQ-026 Single fetch: start_0=1, address_0=16'h0004; memory returns 32'h03000000 one cycle after start_for_memory -> address_for_memory=16'h0004, write_for_memory=0, ready_0 pulse in cycle k+3, data_out_0=32'h03000000.
REQ-027 Simultaneous: start_0 and start_1 held high from reset release, req 1 write of 32'hDEADBEEF to 16'h0010 -> req 0 served first, then req 1 with write_for_memory=1, data_for_memory=32'hDEADBEEF; grant 01 then 10.
REQ-028 Fairness: both requesters continuously re-requesting for 6 transactions -> grants alternate 0,1,0,1,0,1; no ready overlap.
REQ-029 Timeout: start_1 read, ready_from_memory held 0 -> after 255 WAIT cycles, error and ready_1 pulse together, data_out_1 unchanged.
REQ-030 Reset mid-WAIT: assert reset during WAIT of a req 0 fetch -> all outputs 0 immediately, no ready_0; after release with start_0 still high, new fetch issues start_for_memory.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between an instruction-fetch and an execute requester
module mem_port_arbiter #(
  parameter int byte_size      = 8,
  parameter int width          = 4 * byte_size,
  parameter int address_size   = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_0,
  input  logic [address_size-1:0] address_0,
  output logic                    ready_0,
  output logic [width-1:0]        data_out_0,
  input  logic                    start_1,
  input  logic                    write_1,
  input  logic [address_size-1:0] address_1,
  input  logic [width-1:0]        data_in_1,
  output logic                    ready_1,
  output logic [width-1:0]        data_out_1,
  output logic                    start_for_memory,
  output logic                    write_for_memory,
  output logic [address_size-1:0] address_for_memory,
  output logic [width-1:0]        data_for_memory,
  input  logic [width-1:0]        data_from_memory,
  input  logic                    ready_from_memory,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic                    error
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [7:0] wait_last = 8'(timeout_cycles - 1);
  state_t     state;
  logic [7:0] wait_cnt;
  logic       last_grant;
  logic       pick_1;
  logic       wait_end;
  // requester 1 wins when alone, or on a tie when requester 0 was served last
  assign pick_1   = start_1 & (~start_0 | ~last_grant);
  assign wait_end = ready_from_memory | (wait_cnt == wait_last);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      last_grant         <= 1'b1;
      ready_0            <= 1'b0;
      ready_1            <= 1'b0;
      data_out_0         <= '0;
      data_out_1         <= '0;
      start_for_memory   <= 1'b0;
      write_for_memory   <= 1'b0;
      address_for_memory <= '0;
      data_for_memory    <= '0;
      grant              <= '0;
      busy               <= 1'b0;
      error              <= 1'b0;
    end else begin
      start_for_memory <= 1'b0;
      ready_0          <= 1'b0;
      ready_1          <= 1'b0;
      error            <= 1'b0;
      case (state)
        IDLE: if (start_0 | start_1) begin
          state              <= ISSUE;
          busy               <= 1'b1;
          grant              <= pick_1 ? 2'b10 : 2'b01;
          start_for_memory   <= 1'b1;
          address_for_memory <= pick_1 ? address_1 : address_0;
          write_for_memory   <= pick_1 & write_1;
          data_for_memory    <= pick_1 ? data_in_1 : '0;
        end
        ISSUE: state <= WAIT;
        WAIT: if (wait_end) begin
          state    <= DONE;
          wait_cnt <= '0;
          ready_0  <= grant[0];
          ready_1  <= grant[1];
          error    <= ~ready_from_memory;
          if (ready_from_memory & ~write_for_memory & grant[0]) data_out_0 <= data_from_memory;
          if (ready_from_memory & ~write_for_memory & grant[1]) data_out_1 <= data_from_memory;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        DONE: begin
          state              <= IDLE;
          busy               <= 1'b0;
          last_grant         <= grant[1];
          grant              <= '0;
          write_for_memory   <= 1'b0;
          address_for_memory <= '0;
          data_for_memory    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
